// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: operation codes, MIPS
// opcode/funct values, FSM state encoding and the decoder result bundle.
package alu_issue_defs;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPRN_W = 6;

  typedef logic [OPRN_W-1:0] oprn_t;

  localparam oprn_t OPRN_NOP = 6'd0;
  localparam oprn_t OPRN_ADD = 6'd1;
  localparam oprn_t OPRN_SUB = 6'd2;
  localparam oprn_t OPRN_MUL = 6'd3;
  localparam oprn_t OPRN_SRL = 6'd4;
  localparam oprn_t OPRN_SLL = 6'd5;
  localparam oprn_t OPRN_AND = 6'd6;
  localparam oprn_t OPRN_OR  = 6'd7;
  localparam oprn_t OPRN_NOR = 6'd8;
  localparam oprn_t OPRN_SLT = 6'd9;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_MULI  = 6'h1d;

  localparam logic [5:0] FUNCT_SLL = 6'h01;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2a;
  localparam logic [5:0] FUNCT_MUL = 6'h2c;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request / ALU / result bundle of the ALU issue controller. The controller
// uses the slave modport; the requester-plus-ALU environment uses master.
interface alu_issue_ctrl_if;
  logic [31:0] INSTR;
  logic [31:0] RS_DATA;
  logic [31:0] RT_DATA;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] ALU_OP1;
  logic [31:0] ALU_OP2;
  logic [5:0]  ALU_OPRN;
  logic [31:0] ALU_OUT;
  logic        ALU_ZERO;
  logic [31:0] RES;
  logic        RES_ZERO;
  logic        RES_ILLEGAL;
  logic        RES_VALID;
  logic        RES_READY;

  modport master (
    output INSTR, RS_DATA, RT_DATA, IN_VALID, ALU_OUT, ALU_ZERO, RES_READY,
    input  IN_READY, ALU_OP1, ALU_OP2, ALU_OPRN, RES, RES_ZERO, RES_ILLEGAL, RES_VALID
  );

  modport slave (
    input  INSTR, RS_DATA, RT_DATA, IN_VALID, ALU_OUT, ALU_ZERO, RES_READY,
    output IN_READY, ALU_OP1, ALU_OP2, ALU_OPRN, RES, RES_ZERO, RES_ILLEGAL, RES_VALID
  );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational MIPS opcode/funct to ALU operation decoder (module alu_issue_decode).
// I-type opcodes are decoded only when ALU_ISSUE_IMM_EN is defined.
module alu_issue_decode
  import alu_issue_defs::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output oprn_t       oprn,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  // Register-index fields are resolved upstream by the register file.
  logic        unused_reg_fields;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign shamt             = instr[10:6];
  assign imm               = instr[15:0];
  assign imm_sext          = {{16{imm[15]}}, imm};
  assign imm_zext          = {16'h0000, imm};
  assign unused_reg_fields = ^instr[25:11];

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    oprn    = OPRN_NOP;
    op1     = rs_data;
    op2     = rt_data;
    illegal = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        illegal = 1'b0;
        case (funct)
          FUNCT_ADD: oprn = OPRN_ADD;
          FUNCT_SUB: oprn = OPRN_SUB;
          FUNCT_MUL: oprn = OPRN_MUL;
          FUNCT_SRL: begin oprn = OPRN_SRL; op2 = {27'b0, shamt}; end
          FUNCT_SLL: begin oprn = OPRN_SLL; op2 = {27'b0, shamt}; end
          FUNCT_AND: oprn = OPRN_AND;
          FUNCT_OR:  oprn = OPRN_OR;
          FUNCT_NOR: oprn = OPRN_NOR;
          FUNCT_SLT: oprn = OPRN_SLT;
          default:   illegal = 1'b1;
        endcase
      end
`ifdef ALU_ISSUE_IMM_EN
      OPC_ADDI: begin illegal = 1'b0; oprn = OPRN_ADD; op2 = imm_sext; end
      OPC_MULI: begin illegal = 1'b0; oprn = OPRN_MUL; op2 = imm_sext; end
      OPC_SLTI: begin illegal = 1'b0; oprn = OPRN_SLT; op2 = imm_sext; end
      OPC_ANDI: begin illegal = 1'b0; oprn = OPRN_AND; op2 = imm_zext; end
      OPC_ORI:  begin illegal = 1'b0; oprn = OPRN_OR;  op2 = imm_zext; end
`else
      // Immediate forms fall through to the illegal path in this build.
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the combinational 32-bit ALU: IDLE/EXEC/DONE FSM,
// registered operands, captured result. Optional I-type decode: ALU_ISSUE_IMM_EN.
module alu_issue_ctrl
  import alu_issue_defs::*;
(
  input  logic          CLK,
  input  logic          RST,
  alu_issue_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] alu_op1_q, alu_op1_d;
  logic [31:0] alu_op2_q, alu_op2_d;
  oprn_t       alu_oprn_q, alu_oprn_d;
  logic [31:0] res_q, res_d;
  logic        res_zero_q, res_zero_d;
  logic        res_illegal_q, res_illegal_d;
  logic        res_valid_q, res_valid_d;

  oprn_t       dec_oprn;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic        dec_illegal;

  alu_issue_decode u_decode (
    .instr   (bus.INSTR),
    .rs_data (bus.RS_DATA),
    .rt_data (bus.RT_DATA),
    .oprn    (dec_oprn),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_oprn_d    = alu_oprn_q;
    res_d         = res_q;
    res_zero_d    = res_zero_q;
    res_illegal_d = res_illegal_q;
    res_valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.IN_VALID) begin
          if (dec_illegal) begin
            res_d         = '0;
            res_zero_d    = 1'b1;
            res_illegal_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            alu_op1_d  = dec_op1;
            alu_op2_d  = dec_op2;
            alu_oprn_d = dec_oprn;
            state_d    = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        res_d         = bus.ALU_OUT;
        res_zero_d    = bus.ALU_ZERO;
        res_illegal_d = 1'b0;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        // RES_VALID rises one cycle after entering DONE, once RES has been stable a full cycle.
        if (res_valid_q && bus.RES_READY) begin
          state_d = ST_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_oprn_q    <= OPRN_NOP;
      res_q         <= '0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_oprn_q    <= alu_oprn_d;
      res_q         <= res_d;
      res_zero_q    <= res_zero_d;
      res_illegal_q <= res_illegal_d;
      res_valid_q   <= res_valid_d;
    end
  end

  // Gated by RST so the requester sees "not ready" for the whole reset interval.
  assign bus.IN_READY    = (state_q == ST_IDLE) && RST;
  assign bus.ALU_OP1     = alu_op1_q;
  assign bus.ALU_OP2     = alu_op2_q;
  assign bus.ALU_OPRN    = alu_oprn_q;
  assign bus.RES         = res_q;
  assign bus.RES_ZERO    = res_zero_q;
  assign bus.RES_ILLEGAL = res_illegal_q;
  assign bus.RES_VALID   = res_valid_q;

endmodule
